load_store_unit: RTL

- Memory-side counterpart of the core's control path.
- Consumes the memory-stage request from the datapath: wr_en, byte_en (unshifted size mask 0001/0011/1111), signed, address and store data.
- Drives a req/gnt/rvalid data bus with one outstanding transaction, and stalls the core until the transaction completes.
- Returns sign- or zero-extended load data, and flags misaligned accesses and bus errors.

---
 rtl/load_store_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns MEM-stage requests into single-outstanding req/gnt/rvalid
// bus transactions, stalls the core meanwhile and returns lane-extracted load data.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic        wr_en_i,
  input  logic [3:0]  byte_en_i,
  input  logic        signed_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_t;

  typedef struct packed {
    logic        we;
    logic        sgn;
    logic [1:0]  size;   // 0 byte, 1 half, 2 word
    logic [1:0]  lo;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nxt;
  req_t        cap;
  logic [7:0]  cnt;
  logic        err_q, mis_q;
  logic [31:0] rdata_q;
  logic        fault, accept, timeout;
  logic [1:0]  size_in;
  logic [31:0] sh, ext;

  always_comb begin
    size_in = 2'd0;
    fault   = 1'b0;
    case (byte_en_i)
      4'b0001: size_in = 2'd0;
      4'b0011: begin size_in = 2'd1; fault = addr_i[0];    end
      4'b1111: begin size_in = 2'd2; fault = |addr_i[1:0]; end
      default: fault = 1'b1;
    endcase
  end

  assign accept  = (state == IDLE) && req_valid_i && !fault;
  assign timeout = (cnt == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = ADDR;
      ADDR: if (bus_gnt_i) state_nxt = RESP;
      RESP: if (bus_rvalid_i || timeout) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pull the addressed field down to bit 0, then extend.
  always_comb begin
    sh = bus_rdata_i >> {cap.lo, 3'b000};
    case (cap.size)
      2'd0:    ext = {{24{cap.sgn & sh[7]}}, sh[7:0]};
      2'd1:    ext = {{16{cap.sgn & sh[15]}}, sh[15:0]};
      default: ext = sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cap     <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      mis_q <= (state == IDLE) && req_valid_i && fault;
      cnt   <= (state == RESP) ? cnt + 8'd1 : 8'd0;
      if (accept) begin
        cap.we    <= wr_en_i;
        cap.sgn   <= signed_i;
        cap.size  <= size_in;
        cap.lo    <= addr_i[1:0];
        cap.addr  <= {addr_i[31:2], 2'b00};
        cap.be    <= byte_en_i << addr_i[1:0];
        cap.wdata <= wdata_i << {addr_i[1:0], 3'b000};
        err_q     <= 1'b0;
      end
      if (state == RESP) begin
        if (bus_rvalid_i) begin
          err_q <= bus_err_i;
          if (!cap.we) rdata_q <= bus_err_i ? 32'd0 : ext;
        end else if (timeout) begin
          err_q <= 1'b1;
          if (!cap.we) rdata_q <= 32'd0;
        end
      end
    end
  end

  assign stall_o       = accept || (state == ADDR) || (state == RESP);
  assign bus_req_o     = (state == ADDR);
  assign bus_we_o      = (state == ADDR) && cap.we;
  assign bus_addr_o    = cap.addr;
  assign bus_be_o      = cap.be;
  assign bus_wdata_o   = cap.wdata;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = (state == DONE) && !cap.we && !err_q;
  assign bus_err_o     = (state == DONE) && err_q;
  assign misaligned_o  = mis_q;

endmodule
